// File: rtl/led_status_driver_pkg.sv
// led_status_pkg: shared state encoding, LED slot map and link count for the LED status path
package led_status_pkg;
  localparam int N_LINKS = 4;
  localparam int LED_HB = 0;
  localparam int LED_LINK0 = 1;
  localparam int LED_STICKY = 5;
  localparam int LED_ALLLOCK = 6;
  typedef logic [1:0] state_t;
  localparam state_t LT_ALL_ON = 2'd0;
  localparam state_t LT_WALK = 2'd1;
  localparam state_t RUN = 2'd2;
endpackage

// File: rtl/led_status_driver_tick_gen.sv
// led_tick_gen: free-running divider producing a one-cycle tick every TICK_DIV clocks
module led_tick_gen #(
  parameter int TICK_DIV = 400_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == W'(TICK_DIV - 1);
  // count 0..TICK_DIV-1, restarting after each tick
  always_ff @(posedge clk_i)
    cnt_q <= (rst_i || tick_o) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/led_status_driver.sv
// led_status_driver: front-panel LED stage with lamp test, error stretch, sticky error and PWM dimming
module led_status_driver
  import led_status_pkg::*;
#(
  parameter int TICK_DIV       = 400_000,
  parameter int ERR_HOLD_TICKS = 5,
  parameter int LAMP_TICKS     = 50,
  parameter int WALK_TICKS     = 10,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic               tmb_clock0,
  input  logic               reset,
  input  logic               heart_beat,
  input  logic [N_LINKS-1:0] prbs_locked,
  input  logic [N_LINKS-1:0] prbs_err,
  input  logic               err_clear,
  input  logic               lamp_test_req,
  input  logic [3:0]         pwm_duty,
  output logic [7:0]         led_n,
  output logic               lamp_test_busy
);
  localparam int TW = $clog2(LAMP_TICKS > WALK_TICKS ? LAMP_TICKS : WALK_TICKS);
  localparam int HW = $clog2(ERR_HOLD_TICKS + 1);
  logic                        tick, start, pwm_on, busy_q, busy_d, sticky_q, sticky_d;
  state_t                      state_q, state_d;
  logic [TW-1:0]               tmr_q, tmr_d;
  logic [2:0]                  idx_q, idx_d;
  logic [3:0]                  pwm_cnt_q;
  logic [N_LINKS-1:0][HW-1:0]  hold_q, hold_d;
  logic [N_LINKS-1:0]          held;
  logic [7:0]                  status, lit, led_q;
  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i (tmb_clock0),
    .rst_i (reset),
    .tick_o(tick)
  );
  assign start    = (state_q == RUN) && lamp_test_req;
  assign sticky_d = (|prbs_err) | (sticky_q & ~err_clear);
  assign pwm_on   = (&pwm_duty) | (pwm_cnt_q < pwm_duty);
  assign busy_d   = start || (state_q != RUN);
  // lamp-test sequencing: all-on phase, then one LED per walk slot, then RUN
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    if (start) begin
      state_d = LT_ALL_ON;
      tmr_d   = '0;
      idx_d   = '0;
    end else if (tick && state_q == LT_ALL_ON) begin
      state_d = (tmr_q == TW'(LAMP_TICKS - 1)) ? LT_WALK : LT_ALL_ON;
      tmr_d   = (tmr_q == TW'(LAMP_TICKS - 1)) ? '0 : tmr_q + 1'b1;
      idx_d   = '0;
    end else if (tick && state_q == LT_WALK) begin
      state_d = (tmr_q == TW'(WALK_TICKS - 1) && idx_q == 3'd7) ? RUN : LT_WALK;
      tmr_d   = (tmr_q == TW'(WALK_TICKS - 1)) ? '0 : tmr_q + 1'b1;
      idx_d   = (tmr_q == TW'(WALK_TICKS - 1) && idx_q != 3'd7) ? idx_q + 3'd1 : idx_q;
    end
  end
  // per-link stretch: a strobe reloads, ticks drain to zero; the reload beats a coincident tick
  always_comb begin
    for (int i = 0; i < N_LINKS; i++) begin
      hold_d[i] = prbs_err[i] ? HW'(ERR_HOLD_TICKS) :
                  (tick && hold_q[i] != '0) ? hold_q[i] - 1'b1 : hold_q[i];
      held[i]   = hold_d[i] != '0;
    end
  end
  // LED image from next-cycle values so every input reaches the pins one clock later
  always_comb begin
    status                         = '0;
    status[LED_HB]                 = heart_beat;
    status[LED_LINK0 +: N_LINKS]   = prbs_locked & ~held;
    status[LED_STICKY]             = sticky_d;
    status[LED_ALLLOCK]            = &prbs_locked;
    lit = (start || state_q == LT_ALL_ON) ? 8'hFF :
          (state_q == LT_WALK) ? 8'd1 << idx_q : status & {8{pwm_on}};
  end
  // state and registered outputs; reset forces every LED dark immediately
  always_ff @(posedge tmb_clock0) begin
    if (reset) begin
      state_q   <= LT_ALL_ON;
      tmr_q     <= '0;
      idx_q     <= '0;
      pwm_cnt_q <= '0;
      hold_q    <= '0;
      sticky_q  <= 1'b0;
      led_q     <= {8{LED_ACTIVE_LOW}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      idx_q     <= idx_d;
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      hold_q    <= hold_d;
      sticky_q  <= sticky_d;
      led_q     <= lit ^ {8{LED_ACTIVE_LOW}};
      busy_q    <= busy_d;
    end
  end
  assign led_n          = led_q;
  assign lamp_test_busy = busy_q;
endmodule
